// File: rtl/mux4_rr_sel_pkg.sv
// Shared types and constants for the round-robin mux select generator.
package mux4_rr_sel_pkg;

    localparam int unsigned MUX_N = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    function automatic logic [MUX_N-1:0] sel_onehot(input logic [SEL_W-1:0] s);
        return MUX_N'(1) << s;
    endfunction

endpackage

// File: rtl/mux4_rr_sel_rr_pick4.sv
// Rotating-priority picker: searches ptr+1, ptr+2, ptr+3, ptr and returns the first requester.
module rr_pick4
    import mux4_rr_sel_pkg::*;
(
    input  logic [MUX_N-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] win,
    output logic             any
);

    logic [SEL_W-1:0] w_idx;

    always_comb begin
        win   = '0;
        any   = 1'b0;
        w_idx = '0;
        for (int i = 1; i <= int'(MUX_N); i++) begin
            w_idx = ptr + SEL_W'(i);
            if (!any && req[w_idx]) begin
                win = w_idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_sel.sv
// Round-robin select generator for a 4:1 mux: grants one requester at a time for a
// programmable dwell and drives registered sel / one-hot grant / valid / switch.
module mux4_rr_sel
    import mux4_rr_sel_pkg::*;
#(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [MUX_N-1:0]   req,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   sel,
    output logic [MUX_N-1:0]   grant,
    output logic               valid,
    output logic               switch
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] w_cnt_nxt;
    logic [SEL_W-1:0]   r_ptr;
    logic [SEL_W-1:0]   w_ptr_nxt;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic [MUX_N-1:0]   r_grant;
    logic [MUX_N-1:0]   w_grant_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic               r_switch;
    logic               w_switch_nxt;

    logic [SEL_W-1:0]   w_win;
    logic               w_any;
    logic               w_end;
    logic               w_load;

    rr_pick4 u_pick (
        .req (req),
        .ptr (r_ptr),
        .win (w_win),
        .any (w_any)
    );

    // Grant ends when the dwell is exhausted or the granted source lets go.
    assign w_end  = (r_cnt == '0) || !req[r_sel];
    assign w_load = en && w_any && ((r_state == S_IDLE) || w_end);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (en && w_any) w_state_nxt = S_HOLD;
            S_HOLD:  if (!en || (w_end && !w_any)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_sel_nxt    = r_sel;
        w_ptr_nxt    = r_ptr;
        w_cnt_nxt    = r_cnt;
        w_grant_nxt  = r_grant;
        w_valid_nxt  = r_valid;
        w_switch_nxt = 1'b0;
        if (w_load) begin
            w_sel_nxt    = w_win;
            w_ptr_nxt    = w_win;
            w_grant_nxt  = sel_onehot(w_win);
            w_valid_nxt  = 1'b1;
            w_switch_nxt = 1'b1;
            w_cnt_nxt    = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
        end else if ((r_state == S_IDLE) || !en || w_end) begin
            w_grant_nxt = '0;
            w_valid_nxt = 1'b0;
        end else begin
            w_cnt_nxt = r_cnt - DWELL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel    <= '0;
            r_ptr    <= SEL_W'(MUX_N - 1);
            r_cnt    <= '0;
            r_grant  <= '0;
            r_valid  <= 1'b0;
            r_switch <= 1'b0;
        end else begin
            r_sel    <= w_sel_nxt;
            r_ptr    <= w_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_grant  <= w_grant_nxt;
            r_valid  <= w_valid_nxt;
            r_switch <= w_switch_nxt;
        end
    end

    assign sel    = r_sel;
    assign grant  = r_grant;
    assign valid  = r_valid;
    assign switch = r_switch;

endmodule
